// File: rtl/parallel2serial.sv
// rtl/parallel2serial.sv - FIFO-buffered word framer: start bit, LSB-first data, stop bits

// Small circular word buffer; fullness is decided by the occupancy count.
module p2s_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [W-1:0]               wdata,
   input  logic                       pop,
   output logic [W-1:0]               rdata,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;

   // Storage array: written on push, contents need no reset because cnt gates reads.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Occupancy update; a simultaneous push and pop leaves it unchanged.
   always_comb begin
      cnt_next = cnt;
      case ({push, pop})
         2'b10:   cnt_next = cnt + 1'b1;
         2'b01:   cnt_next = cnt - 1'b1;
         default: cnt_next = cnt;
      endcase
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         cnt <= cnt_next;
      end
   end

   assign rdata = mem[rd_ptr];
   assign count = cnt;

endmodule

// Framer top: buffers words and shifts each out as one frame on a high-idle line.
module parallel2serial #(
   parameter int DATA_W     = 8,
   parameter int STOP_BITS  = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            Clock,
   input  logic                            iReset,
   input  logic [DATA_W-1:0]               iData,
   input  logic                            iValid,
   output logic                            oReady,
   output logic                            o1b,
   output logic                            oBusy,
   output logic [$clog2(FIFO_DEPTH):0]     oCount
);

   localparam int CW   = $clog2(FIFO_DEPTH) + 1;
   localparam int CNTW = $clog2(DATA_W + STOP_BITS);

   localparam logic [CW-1:0]   DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [CNTW-1:0] LAST_DATA = CNTW'(DATA_W - 1);
   localparam logic [CNTW-1:0] LAST_STOP = CNTW'(STOP_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [DATA_W-1:0]   shift;
   logic [DATA_W-1:0]   shift_next;
   logic [CNTW-1:0]     bitcnt;
   logic [CNTW-1:0]     bitcnt_next;
   logic                line_next;
   logic                busy_next;

   logic                push;
   logic                pop;
   logic                fifo_empty;
   logic [DATA_W-1:0]   head;
   logic [CW-1:0]       count;

   // Inputs are ignored while reset is asserted; the pop is likewise suppressed.
   assign push       = iValid && oReady && !iReset;
   assign fifo_empty = (count == '0);
   assign oReady     = (count < DEPTH_C);
   assign oCount     = count;

   p2s_fifo #(
      .W     (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (Clock),
      .rst   (iReset),
      .push  (push),
      .wdata (iData),
      .pop   (pop),
      .rdata (head),
      .count (count)
   );

   // Next-state logic; line_next is the bit the line will carry during the next state,
   // so o1b stays registered and the frame starts one edge after the word is available.
   always_comb begin
      state_next  = state;
      shift_next  = shift;
      bitcnt_next = bitcnt;
      line_next   = 1'b1;
      busy_next   = 1'b1;
      pop         = 1'b0;
      case (state)
         S_IDLE: begin
            busy_next = 1'b0;
            if (!fifo_empty && !iReset) begin
               pop        = 1'b1;
               shift_next = head;
               state_next = S_START;
               line_next  = 1'b0;
               busy_next  = 1'b1;
            end
         end
         S_START: begin
            state_next  = S_DATA;
            bitcnt_next = '0;
            line_next   = shift[0];
            shift_next  = shift >> 1;
         end
         S_DATA: begin
            if (bitcnt == LAST_DATA) begin
               state_next  = S_STOP;
               bitcnt_next = '0;
               line_next   = 1'b1;
            end else begin
               bitcnt_next = bitcnt + 1'b1;
               line_next   = shift[0];
               shift_next  = shift >> 1;
            end
         end
         S_STOP: begin
            if (bitcnt == LAST_STOP) begin
               bitcnt_next = '0;
               if (!fifo_empty && !iReset) begin
                  // Chain straight into the next frame with no idle bit.
                  pop        = 1'b1;
                  shift_next = head;
                  state_next = S_START;
                  line_next  = 1'b0;
               end else begin
                  state_next = S_IDLE;
                  busy_next  = 1'b0;
               end
            end else begin
               bitcnt_next = bitcnt + 1'b1;
            end
         end
         default: begin
            state_next = S_IDLE;
            busy_next  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any frame in flight immediately.
   always_ff @(posedge Clock) begin
      if (iReset) begin
         state  <= S_IDLE;
         shift  <= '0;
         bitcnt <= '0;
         o1b    <= 1'b1;
         oBusy  <= 1'b0;
      end else begin
         state  <= state_next;
         shift  <= shift_next;
         bitcnt <= bitcnt_next;
         o1b    <= line_next;
         oBusy  <= busy_next;
      end
   end

endmodule

// File: tb/tb_parallel2serial.sv
// tb/tb_parallel2serial.sv - directed bench for parallel2serial

module tb_parallel2serial;

   logic       clk;
   logic       iReset;
   logic [7:0] iData;
   logic       iValid;
   logic       oReady;
   logic       o1b;
   logic       oBusy;
   logic [2:0] oCount;

   parallel2serial dut (
      .Clock  (clk),
      .iReset (iReset),
      .iData  (iData),
      .iValid (iValid),
      .oReady (oReady),
      .o1b    (o1b),
      .oBusy  (oBusy),
      .oCount (oCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic       cap_en = 1'b0;
   logic       line_q [$];
   logic       busy_q [$];
   logic [2:0] cnt_q  [$];
   logic       rdy_q  [$];
   logic [7:0] expw   [8];

   // Sample index j reflects the state after edge N+j-1, N being the first stimulus edge.
   always @(negedge clk) begin
      if (cap_en) begin
         line_q.push_back(o1b);
         busy_q.push_back(oBusy);
         cnt_q.push_back(oCount);
         rdy_q.push_back(oReady);
      end
   end

   typedef struct {
      logic [7:0]  data;
      logic [10:0] frame;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic start_capture();
      line_q.delete();
      busy_q.delete();
      cnt_q.delete();
      rdy_q.delete();
      cap_en = 1'b1;
   endtask

   task automatic check_frames(input string name, input int n);
      logic [10:0] fr;
      logic [10:0] bz;
      int          base;
      if (line_q.size() < 3 + 11 * n) begin
         chk($sformatf("%s capture length", name), line_q.size(), 3 + 11 * n);
         return;
      end
      for (int f = 0; f < n; f++) begin
         base = 2 + 11 * f;
         for (int b = 0; b < 11; b++) begin
            fr[b] = line_q[base + b];
            bz[b] = busy_q[base + b];
         end
         chk($sformatf("%s frame%0d", name, f), fr, {2'b11, expw[f], 1'b0});
         chk($sformatf("%s busy%0d", name, f), bz, 11'h7FF);
      end
      chk($sformatf("%s idle line", name), line_q[2 + 11 * n], 1'b1);
      chk($sformatf("%s idle busy", name), busy_q[2 + 11 * n], 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      int idx;
      int guard;
      int maxc;
      logic rdy;

      tbl[0] = '{8'h8B, 11'h716};
      tbl[1] = '{8'h00, 11'h600};
      tbl[2] = '{8'hFF, 11'h7FE};
      tbl[3] = '{8'hA5, 11'h74A};
      tbl[4] = '{8'h0F, 11'h61E};
      tbl[5] = '{8'h61, 11'h6C2};

      // Reset held two cycles, then idle line
      iReset = 1'b1;
      iValid = 1'b0;
      iData  = '0;
      repeat (2) @(posedge clk);
      #1 iReset = 1'b0;
      chk("reset o1b", o1b, 1'b1);
      chk("reset ready", oReady, 1'b1);
      chk("reset count", oCount, 3'd0);
      chk("reset busy", oBusy, 1'b0);
      start_capture();
      repeat (20) @(posedge clk);
      #1 cap_en = 1'b0;
      bad = 0;
      foreach (line_q[j]) if (line_q[j] !== 1'b1 || busy_q[j] !== 1'b0) bad++;
      chk("idle after reset", bad, 0);

      // Single words from the vector table
      for (int t = 0; t < 6; t++) begin
         @(posedge clk);
         #1 start_capture();
         iValid = 1'b1;
         iData  = tbl[t].data;
         @(posedge clk);
         #1 iValid = 1'b0;
         chk($sformatf("single%0d count after push", t), oCount, 3'd1);
         repeat (14) @(posedge clk);
         #1 cap_en = 1'b0;
         begin
            logic [10:0] fr;
            logic [10:0] bz;
            for (int b = 0; b < 11; b++) begin
               fr[b] = line_q[2 + b];
               bz[b] = busy_q[2 + b];
            end
            chk($sformatf("single%0d pre-start line", t), line_q[1], 1'b1);
            chk($sformatf("single%0d frame", t), fr, tbl[t].frame);
            chk($sformatf("single%0d busy", t), bz, 11'h7FF);
            chk($sformatf("single%0d idle line", t), line_q[13], 1'b1);
            chk($sformatf("single%0d idle busy", t), busy_q[13], 1'b0);
         end
      end

      // Back-to-back three words
      expw[0] = 8'h0F; expw[1] = 8'hF0; expw[2] = 8'h61;
      @(posedge clk);
      #1 start_capture();
      iValid = 1'b1;
      iData  = expw[0];
      @(posedge clk); #1 iData = expw[1];
      @(posedge clk); #1 iData = expw[2];
      @(posedge clk); #1 iValid = 1'b0;
      repeat (36) @(posedge clk);
      #1 cap_en = 1'b0;
      check_frames("b2b", 3);

      // Full FIFO with iValid held high; each word held until accepted
      expw[0] = 8'h11; expw[1] = 8'hA2; expw[2] = 8'h3C;
      expw[3] = 8'h4D; expw[4] = 8'hE5; expw[5] = 8'h96;
      @(posedge clk);
      #1 start_capture();
      iValid = 1'b1;
      iData  = expw[0];
      idx    = 0;
      guard  = 0;
      while (idx < 6 && guard < 200) begin
         @(negedge clk) rdy = oReady;
         @(posedge clk);
         #1 guard++;
         if (rdy) begin
            idx++;
            if (idx < 6) iData = expw[idx];
            else iValid = 1'b0;
         end
      end
      iValid = 1'b0;
      chk("full handshake completed", idx, 6);
      repeat (60) @(posedge clk);
      #1 cap_en = 1'b0;
      chk("full count at N+4", cnt_q[5], 3'd4);
      chk("full ready at N+4", rdy_q[5], 1'b0);
      chk("full count at N+11", cnt_q[12], 3'd4);
      chk("full ready at N+11", rdy_q[12], 1'b0);
      chk("full count after pop", cnt_q[13], 3'd3);
      chk("full ready after pop", rdy_q[13], 1'b1);
      chk("full count after refill", cnt_q[14], 3'd4);
      maxc = 0;
      foreach (cnt_q[j]) if (int'(cnt_q[j]) > maxc) maxc = int'(cnt_q[j]);
      chk("full max count", maxc, 4);
      check_frames("full", 6);
      chk("full drained count", cnt_q[68], 3'd0);

      // Push at the same edge as the pop, with two words queued
      expw[0] = 8'h3A; expw[1] = 8'hC5; expw[2] = 8'h7E; expw[3] = 8'h19;
      @(posedge clk);
      #1 start_capture();
      iValid = 1'b1;
      iData  = expw[0];
      @(posedge clk); #1 iData = expw[1];
      @(posedge clk); #1 iData = expw[2];
      @(posedge clk); #1 iValid = 1'b0;
      repeat (9) @(posedge clk);
      #1 iValid = 1'b1;
      iData = expw[3];
      @(posedge clk);
      #1 iValid = 1'b0;
      repeat (40) @(posedge clk);
      #1 cap_en = 1'b0;
      chk("simul count before", cnt_q[12], 3'd2);
      chk("simul count after", cnt_q[13], 3'd2);
      check_frames("simul", 4);

      // Reset during data bit 3 with two words queued; iValid high during reset
      @(posedge clk);
      #1 iValid = 1'b1;
      iData = 8'hF7;
      @(posedge clk); #1 iData = 8'h81;
      @(posedge clk); #1 iData = 8'h42;
      @(posedge clk); #1 iValid = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("midreset bit3 before", o1b, 1'b0);
      chk("midreset count before", oCount, 3'd2);
      iReset = 1'b1;
      iValid = 1'b1;
      iData  = 8'h55;
      @(posedge clk);
      #1 iReset = 1'b0;
      iValid = 1'b0;
      chk("midreset o1b", o1b, 1'b1);
      chk("midreset count", oCount, 3'd0);
      chk("midreset busy", oBusy, 1'b0);
      chk("midreset ready", oReady, 1'b1);
      start_capture();
      repeat (25) @(posedge clk);
      #1 cap_en = 1'b0;
      bad = 0;
      foreach (line_q[j]) if (line_q[j] !== 1'b1 || busy_q[j] !== 1'b0 || cnt_q[j] !== 3'd0) bad++;
      chk("midreset no further frames", bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
